// File: rtl/arbitro_display_if.sv
// Requester/display bundle for the two-port display digit arbiter.
interface arbitro_display_if #(
  parameter int unsigned P_DATA_W = 4
) ();
  logic                i_Req_A;
  logic [1:0]          i_Dig_A;
  logic [P_DATA_W-1:0] i_Val_A;
  logic                i_Req_B;
  logic [1:0]          i_Dig_B;
  logic [P_DATA_W-1:0] i_Val_B;
  logic                i_Frame;
  logic                o_Ack_A;
  logic                o_Ack_B;
  logic [P_DATA_W-1:0] o_Datos1;
  logic [P_DATA_W-1:0] o_Datos2;
  logic [P_DATA_W-1:0] o_Datos3;
  logic [P_DATA_W-1:0] o_Datos4;
  logic                o_Pend;

  modport master (
    output i_Req_A, i_Dig_A, i_Val_A, i_Req_B, i_Dig_B, i_Val_B, i_Frame,
    input  o_Ack_A, o_Ack_B, o_Datos1, o_Datos2, o_Datos3, o_Datos4, o_Pend
  );

  modport slave (
    input  i_Req_A, i_Dig_A, i_Val_A, i_Req_B, i_Dig_B, i_Val_B, i_Frame,
    output o_Ack_A, o_Ack_B, o_Datos1, o_Datos2, o_Datos3, o_Datos4, o_Pend
  );
endinterface

// File: rtl/arbitro_display.sv
// Round-robin arbiter for two four-phase digit writers into a shadow bank,
// committed to the display bank only on a frame strobe so a scan never tears.
module arbitro_display #(
  parameter int unsigned P_DATA_W = 4
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  arbitro_display_if.slave   bus
);

  localparam int unsigned N_DIG = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK_A = 2'd1,
    ACK_B = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                ptr_b_q, ptr_b_d;
  logic                ack_a_q, ack_a_d;
  logic                ack_b_q, ack_b_d;
  logic                dirty_q, dirty_d;
  logic                wr_en_c;
  logic [1:0]          wr_idx_c;
  logic [P_DATA_W-1:0] wr_val_c;
  logic                commit_c;
  logic [P_DATA_W-1:0] shadow_q [N_DIG];
  logic [P_DATA_W-1:0] commit_q [N_DIG];

  // Next state, grant and shadow-write decode
  always_comb begin
    state_d  = state_q;
    ptr_b_d  = ptr_b_q;
    wr_en_c  = 1'b0;
    wr_idx_c = bus.i_Dig_A;
    wr_val_c = bus.i_Val_A;
    unique case (state_q)
      IDLE: begin
        if (bus.i_Req_A && (!bus.i_Req_B || !ptr_b_q)) begin
          state_d  = ACK_A;
          ptr_b_d  = 1'b1;
          wr_en_c  = 1'b1;
        end else if (bus.i_Req_B) begin
          state_d  = ACK_B;
          ptr_b_d  = 1'b0;
          wr_en_c  = 1'b1;
          wr_idx_c = bus.i_Dig_B;
          wr_val_c = bus.i_Val_B;
        end
      end
      ACK_A: if (!bus.i_Req_A) state_d = IDLE;
      ACK_B: if (!bus.i_Req_B) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ack_a_d  = (state_d == ACK_A);
    ack_b_d  = (state_d == ACK_B);
    // A commit copies the pre-write shadow; a same-edge write keeps dirty set
    commit_c = bus.i_Frame && dirty_q;
    dirty_d  = wr_en_c || (dirty_q && !commit_c);
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q <= IDLE;
      ptr_b_q <= 1'b0;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
      dirty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_b_q <= ptr_b_d;
      ack_a_q <= ack_a_d;
      ack_b_q <= ack_b_d;
      dirty_q <= dirty_d;
    end
  end

  // Shadow and committed digit banks
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      for (int i = 0; i < N_DIG; i++) begin
        shadow_q[i] <= '0;
        commit_q[i] <= '0;
      end
    end else begin
      if (wr_en_c) shadow_q[wr_idx_c] <= wr_val_c;
      if (commit_c) begin
        for (int i = 0; i < N_DIG; i++) commit_q[i] <= shadow_q[i];
      end
    end
  end

  assign bus.o_Ack_A  = ack_a_q;
  assign bus.o_Ack_B  = ack_b_q;
  assign bus.o_Pend   = dirty_q;
  assign bus.o_Datos1 = commit_q[0];
  assign bus.o_Datos2 = commit_q[1];
  assign bus.o_Datos3 = commit_q[2];
  assign bus.o_Datos4 = commit_q[3];

endmodule

// File: doc/arbitro_display.md
ARBITRO_DISPLAY -- requirements
Module: arbitro_display

Interface
REQ-001 Parameter P_DATA_W, default 4, bit width of one digit value.
REQ-002 i_Clk  input  1  system clock; all state changes on its rising edge.
REQ-003 i_Rst  input  1  reset, asynchronous assert, active-low.
REQ-004 i_Req_A  input  1  requester A write request, four-phase handshake.
REQ-005 i_Dig_A  input  2  requester A target digit index, 0..3.
REQ-006 i_Val_A  input  P_DATA_W  requester A digit value.
REQ-007 i_Req_B  input  1  requester B write request, four-phase handshake.
REQ-008 i_Dig_B  input  2  requester B target digit index, 0..3.
REQ-009 i_Val_B  input  P_DATA_W  requester B digit value.
REQ-010 i_Frame  input  1  one-cycle strobe marking the display scan wrap.
REQ-011 o_Ack_A  output  1  grant/acknowledge to requester A.
REQ-012 o_Ack_B  output  1  grant/acknowledge to requester B.
REQ-013 o_Datos1..o_Datos4  output  P_DATA_W each  committed digit values 0..3 to the display multiplexer.
REQ-014 o_Pend  output  1  high while shadow bank holds uncommitted writes.

Function
REQ-015 The block SHALL hold a 4-entry shadow bank and a 4-entry committed bank; o_Datos1..4 are driven directly from committed-bank registers.
REQ-016 FSM states: IDLE, ACK_A, ACK_B; encoding is implementation choice.
REQ-017 IDLE, only A requesting: next edge -> ACK_A, shadow[i_Dig_A] <= i_Val_A.
REQ-018 IDLE, only B requesting: next edge -> ACK_B, shadow[i_Dig_B] <= i_Val_B.
REQ-019 IDLE, both requesting: winner is the requester named by round-robin pointer; loser waits, its request held.
REQ-020 Pointer: after a grant to A it SHALL point to B, after a grant to B to A; unchanged while IDLE without grant.
REQ-021 Address/data SHALL be sampled only at the granting edge; later changes ignored.
REQ-022 o_Ack_A = 1 exactly in ACK_A; o_Ack_B = 1 exactly in ACK_B; never both high.
REQ-023 ACK_x: stays while i_Req_x = 1; edge with i_Req_x = 0 -> IDLE, ack falls; no new grant on that same edge.
REQ-024 Latency: ack rises one cycle after the edge sampling the request; minimum handshake period 3 cycles per requester.
REQ-025 Dirty flag SHALL set on every shadow write; o_Pend = dirty flag.
REQ-026 On edge with i_Frame = 1 and dirty = 1: committed bank <= shadow bank (all 4 digits), dirty cleared.
REQ-027 i_Frame = 1 with dirty = 0: committed bank unchanged.
REQ-028 Simultaneous shadow write and commit on one edge: commit copies pre-write shadow contents; dirty stays 1; new value commits on the next frame.
REQ-029 Repeated writes to the same digit before a frame: last write wins; intermediate values never reach o_Datos.
REQ-030 Committed outputs SHALL change only on an i_Frame edge (no tearing mid-scan).

Reset
REQ-031 i_Rst = 0 SHALL immediately force: state IDLE, pointer = A, both banks all zeros, dirty = 0, o_Ack_A = o_Ack_B = 0, o_Pend = 0, o_Datos1..4 = 0.
REQ-032 Reset during ACK_x SHALL abort the handshake; after release requester x must deassert and re-request; a pending held request is re-arbitrated from IDLE with pointer = A.
REQ-033 Release of i_Rst takes effect on the first rising edge with i_Rst = 1.

Verification
REQ-034 A writes dig 2 val 4'h7, no frame -> ack 1 cycle later, o_Pend = 1, o_Datos3 stays 0; then i_Frame pulse -> o_Datos3 = 4'h7, o_Pend = 0.
REQ-035 A and B request same cycle after reset (A: dig0=4'h1, B: dig1=4'h2) -> A acked first, B acked after A releases; single frame -> o_Datos1 = 1, o_Datos2 = 2.
REQ-036 Both requesters hold four back-to-back handshakes -> grants alternate A,B,A,B,...; never both acks high.
REQ-037 Write dig3 = 4'h9 granted on same edge as i_Frame -> o_Datos4 unchanged, o_Pend = 1; next frame -> o_Datos4 = 4'h9.
REQ-038 Assert i_Rst = 0 while in ACK_B with dirty = 1 -> all outputs 0 immediately; after release, B held high gets acked only once arbitration restarts in IDLE.
REQ-039 A writes dig0 = 4'h3 then 4'h5 before any frame -> after frame o_Datos1 = 4'h5, 4'h3 never observed.
